// File: rtl/csa_tree_pipe.sv
// Pipelined multi-operand adder: 3:2 carry-save layers feeding a registered carry-propagate adder.
// Define CSA_TREE_PIPE_ACC_EN to add the acc_clr port and turn the output stage into an accumulator.
module csa_tree_pipe #(
  parameter int unsigned SIZE_I    = 32,
  parameter int unsigned DEPTH     = 10,
  parameter int unsigned SIZE_O    = SIZE_I + $clog2(DEPTH),
  parameter int unsigned REG_EVERY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE_I-1:0] A [0:DEPTH-1],
`ifdef CSA_TREE_PIPE_ACC_EN
  input  logic              acc_clr,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIZE_O-1:0] out_sum
);

  typedef logic [SIZE_O-1:0] word_t;

  function automatic int unsigned next_cnt(input int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  // Operand count present at level k (level 0 = the zero-extended inputs).
  function automatic int unsigned level_cnt(input int unsigned k);
    int unsigned n;
    n = DEPTH;
    for (int unsigned i = 0; i < k; i++) n = next_cnt(n);
    return n;
  endfunction

  function automatic int unsigned calc_layers();
    int unsigned n;
    int unsigned l;
    n = DEPTH;
    l = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (n > 2) begin
        n = next_cnt(n);
        l++;
      end
    end
    return l;
  endfunction

  localparam int unsigned L    = calc_layers();
  localparam int unsigned NREG = (L == 0) ? 0 : (L - 1) / REG_EVERY;

  logic  adv;
  logic  out_valid_q;
  word_t out_sum_q;
  word_t tree_sum;
  word_t sum_d;
  logic  last_vld;
`ifdef CSA_TREE_PIPE_ACC_EN
  logic  last_clr;
`endif

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv;

  // Level k holds the operands after k CSA layers, taken after the stage register if one exists.
  for (genvar k = 0; k <= L; k++) begin : g_lvl
    localparam int unsigned N = level_cnt(k);
    word_t v [N];

    if (k == 0) begin : g_src
      for (genvar j = 0; j < N; j++) begin : g_ext
        assign v[j] = SIZE_O'(A[j]);
      end
    end else begin : g_csa
      localparam int unsigned NP = level_cnt(k - 1);
      word_t c [N];

      for (genvar t = 0; t < NP / 3; t++) begin : g_fa
        word_t x, y, z;
        assign x          = g_lvl[k-1].v[3*t];
        assign y          = g_lvl[k-1].v[3*t+1];
        assign z          = g_lvl[k-1].v[3*t+2];
        assign c[2*t]     = x ^ y ^ z;
        // Carry word shifted up one place; the bit leaving the top is dropped (mod 2^SIZE_O).
        assign c[2*t+1]   = ((x & y) | (x & z) | (y & z)) << 1;
      end

      for (genvar t = 0; t < NP % 3; t++) begin : g_pass
        assign c[2*(NP/3)+t] = g_lvl[k-1].v[3*(NP/3)+t];
      end

      if ((k % REG_EVERY) == 0 && k < L) begin : g_reg
        word_t v_q [N];
        always_ff @(posedge clk) begin
          if (adv) v_q <= c;
        end
        assign v = v_q;
      end else begin : g_comb
        assign v = c;
      end
    end
  end

  assign tree_sum = g_lvl[L].v[0] + g_lvl[L].v[1];

  // Per-stage valid (and acc_clr) bits shift in lockstep with the data registers.
  if (NREG == 0) begin : g_nopipe
    assign last_vld = in_valid;
`ifdef CSA_TREE_PIPE_ACC_EN
    assign last_clr = acc_clr;
`endif
  end else begin : g_pipe
    logic [NREG-1:0] vld_q;
    logic [NREG-1:0] vld_d;

    assign vld_d    = (vld_q << 1) | NREG'(in_valid);
    assign last_vld = vld_q[NREG-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
      end
    end

`ifdef CSA_TREE_PIPE_ACC_EN
    logic [NREG-1:0] clr_q;
    logic [NREG-1:0] clr_d;

    assign clr_d    = (clr_q << 1) | NREG'(acc_clr);
    assign last_clr = clr_q[NREG-1];

    always_ff @(posedge clk) begin
      if (adv) clr_q <= clr_d;
    end
`endif
  end

  always_comb begin
`ifdef CSA_TREE_PIPE_ACC_EN
    sum_d = (last_clr ? '0 : out_sum_q) + tree_sum;
`else
    sum_d = tree_sum;
`endif
  end

  // Bubbles clear out_valid but leave out_sum (and the accumulator) untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else if (adv) begin
      out_valid_q <= last_vld;
      if (last_vld) out_sum_q <= sum_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;

endmodule

// File: tb/tb_csa_tree_pipe.sv
// Self-checking bench for csa_tree_pipe: directed vector table, handshake corner cases,
// and a randomized run against a queue-based arithmetic reference model.
module tb_csa_tree_pipe;

  localparam int unsigned SI = 32;
  localparam int unsigned D  = 10;
  localparam int unsigned SO = 36;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, acc_clr;
  logic [SI-1:0] a [0:D-1];
  logic [SO-1:0] out_sum;

  logic          d2_iv, d2_ir, d2_ov;
  logic [7:0]    d2_a [0:1];
  logic [8:0]    d2_sum;
  logic          d3_iv, d3_ir, d3_ov;
  logic [7:0]    d3_a [0:2];
  logic [9:0]    d3_sum;

  csa_tree_pipe u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
`ifdef CSA_TREE_PIPE_ACC_EN
    .acc_clr   (acc_clr),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  csa_tree_pipe #(.SIZE_I(8), .DEPTH(2), .REG_EVERY(2)) u_d2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (d2_iv),
    .in_ready  (d2_ir),
    .A         (d2_a),
`ifdef CSA_TREE_PIPE_ACC_EN
    .acc_clr   (1'b1),
`endif
    .out_valid (d2_ov),
    .out_ready (1'b1),
    .out_sum   (d2_sum)
  );

  csa_tree_pipe #(.SIZE_I(8), .DEPTH(3), .REG_EVERY(1)) u_d3 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (d3_iv),
    .in_ready  (d3_ir),
    .A         (d3_a),
`ifdef CSA_TREE_PIPE_ACC_EN
    .acc_clr   (1'b1),
`endif
    .out_valid (d3_ov),
    .out_ready (1'b1),
    .out_sum   (d3_sum)
  );

  typedef struct packed {
    logic [D-1:0][SI-1:0] ops;
    logic [SO-1:0]        exp;
  } vec_t;

  vec_t          tbl [6];
  string         tbl_name [6];
  int            errors = 0;
  int            checks = 0;
  logic [SO-1:0] exp_q [$];
  logic [SO-1:0] model_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain modular sum of the operands, optionally accumulated in beat order.
  task automatic model_push();
    logic [SO-1:0] s;
    s = '0;
    for (int i = 0; i < D; i++) s = s + SO'(a[i]);
`ifdef CSA_TREE_PIPE_ACC_EN
    if (!acc_clr) s = s + model_acc;
    model_acc = s;
`endif
    exp_q.push_back(s);
  endtask

  // One cycle with the currently driven inputs: score emission, record acceptance.
  task automatic sb_step();
    #1;
    chk("hs_in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("rnd_extra_beat", out_valid, 1'b0);
      else chk("rnd_sum", out_sum, exp_q.pop_front());
    end
    if (in_valid && in_ready) model_push();
    tick();
  endtask

  task automatic one_beat(input logic [D-1:0][SI-1:0] ops, input logic [SO-1:0] exp,
                          input string nm);
    int n;
    for (int i = 0; i < D; i++) a[i] = ops[i];
    acc_clr   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, 3);
    chk({nm, "_sum"}, out_sum, exp);
    tick();
  endtask

  initial begin
    logic [3:0]           clrs;
    logic [3:0][SO-1:0]   acc_exp;

    // Vector table
    tbl[0].ops = {D{32'hFFFF_FFFF}};  tbl[0].exp = 36'h9_FFFF_FFF6; tbl_name[0] = "all_ones";
    for (int i = 0; i < D; i++) tbl[1].ops[i] = SI'(i + 1);
    tbl[1].exp = 36'd55;               tbl_name[1] = "ramp";
    tbl[2].ops = '0;                   tbl[2].exp = '0;               tbl_name[2] = "zeros";
    tbl[3].ops = '0; tbl[3].ops[0] = 32'hFFFF_FFFF; tbl[3].ops[1] = 32'd1;
    tbl[3].exp = 36'h1_0000_0000;      tbl_name[3] = "carry32";
    tbl[4].ops = {D{32'h8000_0000}};  tbl[4].exp = 36'h5_0000_0000; tbl_name[4] = "msb_all";
    for (int i = 0; i < D; i++) tbl[5].ops[i] = (i % 2 == 0) ? 32'h1234_5678 : 32'h0;
    tbl[5].exp = 36'h0_5B05_B058;      tbl_name[5] = "even_pat";

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0;
    d2_iv = 1'b0; d3_iv = 1'b0; model_acc = '0;
    for (int i = 0; i < D; i++) a[i] = '0;
    d2_a[0] = '0; d2_a[1] = '0;
    for (int i = 0; i < 3; i++) d3_a[i] = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_d2_valid", d2_ov, 1'b0);
    chk("rst_d3_valid", d3_ov, 1'b0);
    tick();

    for (int v = 0; v < 6; v++) one_beat(tbl[v].ops, tbl[v].exp, tbl_name[v]);

    // Degenerate trees: single-register pipelines
    d2_a[0] = 8'hFF; d2_a[1] = 8'h01; d2_iv = 1'b1;
    d3_a[0] = 8'd1;  d3_a[1] = 8'd2;  d3_a[2] = 8'd3; d3_iv = 1'b1;
    #1;
    chk("d2_in_ready", d2_ir, 1'b1);
    chk("d3_in_ready", d3_ir, 1'b1);
    tick();
    d2_a[0] = 8'hFF; d2_a[1] = 8'hFF;
    chk("d2_lat1_valid", d2_ov, 1'b1);
    chk("d2_lat1_sum", d2_sum, 9'h100);
    chk("d3_lat1_valid", d3_ov, 1'b1);
    chk("d3_lat1_sum", d3_sum, 10'd6);
    d3_iv = 1'b0;
    tick();
    d2_iv = 1'b0;
    chk("d2_second_sum", d2_sum, 9'h1FE);
    chk("d3_idle", d3_ov, 1'b0);
    tick();
    chk("d2_idle", d2_ov, 1'b0);

    // Full rate: eight back-to-back beats
    for (int i = 0; i < D; i++) a[i] = SI'(i + 1);
    acc_clr = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 8) in_valid = 1'b0;
      chk("rate_valid", out_valid, (k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) chk("rate_sum", out_sum, 36'd55);
    end

    // Backpressure: two beats in flight, consumer stalls
    out_ready = 1'b0; in_valid = 1'b1;
    tick();
    for (int i = 0; i < D; i++) a[i] = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", out_valid, 1'b1);
      chk("stall_sum", out_sum, 36'd55);
      chk("stall_in_ready", in_ready, 1'b0);
      tick();
    end
    chk("stall_sum_end", out_sum, 36'd55);
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    tick();
    chk("next_valid", out_valid, 1'b1);
    chk("next_sum", out_sum, 36'h9_FFFF_FFF6);
    tick();
    chk("bubble_valid", out_valid, 1'b0);
    chk("bubble_hold_sum", out_sum, 36'h9_FFFF_FFF6);

`ifdef CSA_TREE_PIPE_ACC_EN
    clrs = 4'b1001;
    acc_exp[0] = 36'd55; acc_exp[1] = 36'd110; acc_exp[2] = 36'd165; acc_exp[3] = 36'd55;
    for (int i = 0; i < D; i++) a[i] = SI'(i + 1);
    in_valid = 1'b1; acc_clr = clrs[0];
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k <= 3) acc_clr = clrs[k];
      if (k == 4) in_valid = 1'b0;
      if (k >= 3) begin
        chk("acc_valid", out_valid, 1'b1);
        chk("acc_sum", out_sum, acc_exp[k-3]);
      end
    end
    tick();
`else
    clrs = '0;
    acc_exp = '0;
`endif

    // Reset with two beats in flight
    for (int i = 0; i < D; i++) a[i] = SI'(i + 1);
    out_ready = 1'b1; in_valid = 1'b1; acc_clr = 1'b0;
    tick();
    tick();
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_sum", out_sum, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk("midrst_no_stale", out_valid, 1'b0);
      tick();
    end
    model_acc = '0;

    // Randomized traffic with backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      acc_clr   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < D; i++) a[i] = 32'hFFFF_FFFF;
      end else begin
        for (int i = 0; i < D; i++) a[i] = $urandom;
      end
      sb_step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) sb_step();
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_idle", out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
